alu_operand_sequencer: RTL and testbench
========================================

# alu_operand_sequencer

Front-end controller that drives the combinational ALU from board switches and a single "next" push-button. It collects operand A, operand B and the operator in three button-paced steps, then issues them to the ALU. It captures the result and the N/Z/C/V flags into a status register that the display logic reads. It sits between the board I/O (switches, buttons) and the ALU/7-segment decoders, acting as the initiator of every ALU operation.

## Interface
- WIDTH, 4, operand/result width; matches the ALU instance width
- DEBOUNCE, 50000, consecutive stable cycles required before a button level is accepted (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sw  in  WIDTH  operand switches
- op_sw  in  2  operator switches (0 ADD, 1 SUB, 2 AND, 3 OR)
- btn_next  in  1  raw, asynchronous, active-high step button
- btn_clr  in  1  raw, asynchronous, active-high clear button
- alu_a, alu_b  out  WIDTH  registered operands driven to the ALU
- alu_op  out  2  registered operator driven to the ALU
- alu_result  in  WIDTH  ALU result
- alu_n, alu_z, alu_c, alu_v  in  1  ALU flags
- result_q  out  WIDTH  captured result
- flags_q  out  4  captured {N,Z,C,V}, N in bit 3
- state_code  out  3  current FSM state encoding, for the display
- done  out  1  one-cycle pulse on capture

## Operation
- Each button goes through its own 2-flop synchronizer and then a debouncer.
- Debounced level changes only after the synchronized input differs from it for DEBOUNCE consecutive cycles. Any bounce restarts the count.
- A press is the one-cycle rising edge of the debounced level.
- FSM states: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, CAPTURE=4, SHOW=5.
- LOAD_A: on press, latch sw into a_q and go to LOAD_B.
- LOAD_B: on press, latch sw into b_q and go to LOAD_OP.
- LOAD_OP: on press, latch op_sw into op_q and go to EXEC.
- EXEC: one settle cycle with no sampling, then go to CAPTURE unconditionally.
- CAPTURE: latch alu_result into result_q and {alu_n,alu_z,alu_c,alu_v} into flags_q, assert done, then go to SHOW.
- SHOW: hold all registers. On press, go to LOAD_A. a_q/b_q/op_q keep their old values until overwritten.
- alu_a/alu_b/alu_op are always a_q/b_q/op_q, never the switches directly.
- Presses during EXEC and CAPTURE are ignored and not queued.
- Clear press in any state: go to LOAD_A and zero a_q, b_q, op_q, result_q and flags_q.
- Clear and next pressed in the same cycle: clear wins.
- The block does no arithmetic of its own. result_q and flags_q are exact copies of the ALU outputs at CAPTURE.

## Timing
- Reset (async assert, sync release inside the block): state LOAD_A, state_code 0. alu_a, alu_b, alu_op, result_q, flags_q all 0. done 0. Debouncer levels 0, counters 0.
- Button-to-press latency: 2 sync cycles + DEBOUNCE cycles + 1 edge cycle.
- Register latch and state change occur on the clk edge where the press pulse is high.
- Operator press to done: press edge → EXEC (1 cycle) → CAPTURE, with done high during CAPTURE (2nd cycle after the press edge). SHOW follows on the next edge.
- The ALU combinational path gets one full cycle (EXEC) plus the CAPTURE cycle from operand register to capture.
- A button held continuously produces exactly one press.
- Reset mid-operation aborts immediately with no partial capture.

## Structure
- Package alu_seq_pkg:
  - state enum (3-bit encoding above)
  - operator codes OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- Sub-module button_debouncer (parameter DEBOUNCE): synchronizer, stability counter, level register and rising-edge pulse. Instantiated twice.
- The top holds the FSM, operand/operator registers and capture registers.

## Test plan
- WIDTH=4, DEBOUNCE=4, ALU instance attached.
- Load sw=3, sw=5, op_sw=0 → result_q=8, flags_q=4'b1001 (N=1, V=1, i.e. ALU N,Z,C,V=1,0,0,1), done high for exactly 1 cycle on the 2nd cycle after the op press, state_code 4 then 5.
- Load 5, 5, op_sw=1 → result_q=0, flags_q[2]=1 (Z), flags_q equals the ALU flags at CAPTURE.
- btn_next bounce: 2-cycle high pulses separated by 1 low, then a stable high for 6+ cycles → exactly one press, a_q latched once; the held button gives no second press.
- In LOAD_OP with a_q=3, b_q=5: btn_clr and btn_next rise together → state LOAD_A, alu_a, alu_b, alu_op, result_q and flags_q all 0.
- Assert rst low mid-EXEC → all outputs 0 asynchronously, done never pulses. After release, a full ADD 1+1 gives result_q=2, flags_q=0.
- In SHOW, change sw → alu_a unchanged. Press next → LOAD_A, old a_q retained until the next press.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

  // Sequencer states; the encoding is exported to the display as state_code.
  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_CAPTURE = 3'd4,
    S_SHOW    = 3'd5
  } state_t;

  // Operator codes as presented on op_sw / alu_op.
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  // Bit positions inside flags_q.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/button_debouncer.sv
// Raw push-button conditioner: 2-flop synchronizer, stability counter,
// debounced level register and a one-cycle rising-edge press pulse.
module button_debouncer #(
  parameter int DEBOUNCE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEBOUNCE < 2) ? 2 : $clog2(DEBOUNCE + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  logic          w_sync;

  assign w_sync = r_sync[1];

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], i_btn};
  end

  // Accept a new level only after DEBOUNCE consecutive differing samples;
  // any sample that agrees with the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_sync != r_level) begin
      if (r_cnt == CW'(DEBOUNCE - 1)) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Delayed copy of the level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_level_d <= 1'b0;
    else        r_level_d <= r_level;
  end

  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Button-paced front end for the combinational ALU: collects A, B and the
// operator, gives the ALU a settle cycle, then captures result and flags.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       op_sw,
  input  logic             btn_next,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic [WIDTH-1:0] result_q,
  output logic [3:0]       flags_q,
  output logic [2:0]       state_code,
  output logic             done
);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic             w_press_next;
  logic             w_press_clr;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_ld_a;
  logic             w_ld_b;
  logic             w_ld_op;
  logic             w_cap;
  logic             w_clr;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  // Reset asserts immediately and releases synchronously to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_next (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_btn   (btn_next),
    .o_press (w_press_next)
  );

  button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_clr (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_btn   (btn_clr),
    .o_press (w_press_clr)
  );

  // State register.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_LOAD_A;
    else          r_state <= w_state_nxt;
  end

  // Next state and register enables; clear overrides any step press, and
  // step presses in EXEC/CAPTURE simply fall on the floor.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    w_ld_op     = 1'b0;
    w_cap       = 1'b0;
    w_clr       = w_press_clr;
    if (w_press_clr) begin
      w_state_nxt = S_LOAD_A;
    end else begin
      case (r_state)
        S_LOAD_A:  if (w_press_next) begin w_ld_a  = 1'b1; w_state_nxt = S_LOAD_B;  end
        S_LOAD_B:  if (w_press_next) begin w_ld_b  = 1'b1; w_state_nxt = S_LOAD_OP; end
        S_LOAD_OP: if (w_press_next) begin w_ld_op = 1'b1; w_state_nxt = S_EXEC;    end
        S_EXEC:    w_state_nxt = S_CAPTURE;
        S_CAPTURE: begin w_cap = 1'b1; w_state_nxt = S_SHOW; end
        S_SHOW:    if (w_press_next) w_state_nxt = S_LOAD_A;
        default:   w_state_nxt = S_LOAD_A;
      endcase
    end
  end

  // Operand, operator and capture registers.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_clr) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      if (w_ld_a)  r_a  <= sw;
      if (w_ld_b)  r_b  <= sw;
      if (w_ld_op) r_op <= op_sw;
      if (w_cap) begin
        r_result        <= alu_result;
        r_flags[FLAG_N] <= alu_n;
        r_flags[FLAG_Z] <= alu_z;
        r_flags[FLAG_C] <= alu_c;
        r_flags[FLAG_V] <= alu_v;
      end
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign result_q   = r_result;
  assign flags_q    = r_flags;
  assign state_code = r_state;
  assign done       = (r_state == S_CAPTURE);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: table of ALU operations plus hand sequences for bounce,
// clear/next collision, mid-operation reset and SHOW-state behaviour.
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw;
  logic [1:0]   op_sw;
  logic         btn_next;
  logic         btn_clr;
  logic [W-1:0] alu_a, alu_b, alu_result, result_q;
  logic [1:0]   alu_op;
  logic         alu_n, alu_z, alu_c, alu_v;
  logic [3:0]   flags_q;
  logic [2:0]   state_code;
  logic         done;

  int total = 0;
  int bad   = 0;
  int done_cycles = 0;

  alu_operand_sequencer #(.WIDTH(W), .DEBOUNCE(4)) dut (
    .clk(clk), .rst(rst), .sw(sw), .op_sw(op_sw),
    .btn_next(btn_next), .btn_clr(btn_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z),
    .alu_c(alu_c), .alu_v(alu_v),
    .result_q(result_q), .flags_q(flags_q),
    .state_code(state_code), .done(done)
  );

  always #5 clk = ~clk;

  // Attached 4-bit ALU (C on SUB means no borrow).
  logic [4:0] t;
  always_comb begin
    t = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      OP_ADD: begin
        t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c = t[4];
        alu_v = (alu_a[3] == alu_b[3]) && (t[3] != alu_a[3]);
      end
      OP_SUB: begin
        t = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_c = t[4];
        alu_v = (alu_a[3] != alu_b[3]) && (t[3] != alu_a[3]);
      end
      OP_AND:  t = {1'b0, alu_a & alu_b};
      default: t = {1'b0, alu_a | alu_b};
    endcase
    alu_result = t[3:0];
    alu_n = t[3];
    alu_z = (t[3:0] == 4'd0);
  end

  always @(negedge clk) if (done) done_cycles <= done_cycles + 1;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] res;
    logic [3:0] flg;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Hold next until the state moves (bounded), check it, then release and
  // let the debounced level fall back.
  task automatic step(input logic [3:0] val, input logic [2:0] exp_state, input string nm);
    logic [2:0] cur;
    int n;
    cur = state_code;
    sw = val;
    btn_next = 1'b1;
    n = 0;
    while (state_code == cur && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, state_code, exp_state);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // From LOAD_A: load operands and operator, check done timing and capture.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    step(v.a, 3'd1, $sformatf("v%0d_toB", idx));
    chk($sformatf("v%0d_alu_a", idx), alu_a, v.a);
    step(v.b, 3'd2, $sformatf("v%0d_toOP", idx));
    chk($sformatf("v%0d_alu_b", idx), alu_b, v.b);
    op_sw = v.op;
    btn_next = 1'b1;
    n = 0;
    while (state_code == 3'd2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d_exec", idx), state_code, 3'd3);
    chk($sformatf("v%0d_done_exec", idx), done, 1'b0);
    chk($sformatf("v%0d_alu_op", idx), alu_op, v.op);
    @(negedge clk);
    chk($sformatf("v%0d_capture", idx), state_code, 3'd4);
    chk($sformatf("v%0d_done_cap", idx), done, 1'b1);
    @(negedge clk);
    chk($sformatf("v%0d_show", idx), state_code, 3'd5);
    chk($sformatf("v%0d_done_show", idx), done, 1'b0);
    chk($sformatf("v%0d_result", idx), result_q, v.res);
    chk($sformatf("v%0d_flags", idx), flags_q, v.flg);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    chk($sformatf("v%0d_hold", idx), state_code, 3'd5);
  endtask

  initial begin
    int n;
    int dc;
    logic [8:0] bounce;

    vecs[0] = '{4'd3,  4'd5,  OP_ADD, 4'd8,  4'b1001};
    vecs[1] = '{4'd5,  4'd5,  OP_SUB, 4'd0,  4'b0110};
    vecs[2] = '{4'd1,  4'd1,  OP_ADD, 4'd2,  4'b0000};
    vecs[3] = '{4'd15, 4'd1,  OP_ADD, 4'd0,  4'b0110};
    vecs[4] = '{4'd2,  4'd3,  OP_SUB, 4'd15, 4'b1000};
    vecs[5] = '{4'd12, 4'd10, OP_AND, 4'd8,  4'b1000};
    vecs[6] = '{4'd5,  4'd10, OP_OR,  4'd15, 4'b1000};

    rst = 1'b0; sw = '0; op_sw = '0; btn_next = 1'b0; btn_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", state_code, 3'd0);
    chk("rst_outs", {alu_a, alu_b, alu_op, result_q, flags_q, done}, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_state", state_code, 3'd0);

    // Operation table.
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
      step(4'd0, 3'd0, $sformatf("v%0d_toA", i));
    end

    // Clear and next rise together in LOAD_OP: clear wins.
    step(4'd3, 3'd1, "clr_toB");
    step(4'd5, 3'd2, "clr_toOP");
    btn_clr = 1'b1;
    btn_next = 1'b1;
    n = 0;
    while (state_code == 3'd2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("clr_state", state_code, 3'd0);
    chk("clr_regs", {alu_a, alu_b, alu_op, result_q, flags_q}, 0);
    repeat (12) @(negedge clk);
    chk("clr_held", state_code, 3'd0);
    btn_clr = 1'b0;
    btn_next = 1'b0;
    repeat (12) @(negedge clk);

    // Bounce on next, then a long stable hold gives exactly one press.
    sw = 4'd9;
    bounce = 9'b110110110;
    for (int i = 8; i >= 0; i--) begin
      btn_next = bounce[i];
      @(negedge clk);
    end
    chk("bounce_nopress", state_code, 3'd0);
    btn_next = 1'b1;
    n = 0;
    while (state_code == 3'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bounce_press", state_code, 3'd1);
    chk("bounce_a", alu_a, 4'd9);
    sw = 4'd6;
    repeat (12) @(negedge clk);
    chk("held_state", state_code, 3'd1);
    chk("held_b", alu_b, 4'd0);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);

    // Reset while in EXEC: everything clears at once, no capture.
    step(4'd1, 3'd2, "rst_toOP");
    op_sw = OP_ADD;
    btn_next = 1'b1;
    n = 0;
    while (state_code == 3'd2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst_exec_reached", state_code, 3'd3);
    dc = done_cycles;
    rst = 1'b0;
    btn_next = 1'b0;
    #1;
    chk("rst_mid_state", state_code, 3'd0);
    chk("rst_mid_outs", {alu_a, alu_b, alu_op, result_q, flags_q, done}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_no_done", done_cycles, dc);
    chk("rst_after_state", state_code, 3'd0);
    run_vec(vecs[2], 9);

    // SHOW ignores the switches; next returns to LOAD_A keeping a_q.
    sw = 4'd12;
    repeat (5) @(negedge clk);
    chk("show_a_hold", alu_a, 4'd1);
    step(4'd12, 3'd0, "show_toA");
    chk("loadA_a_kept", alu_a, 4'd1);
    chk("loadA_res_kept", result_q, 4'd2);
    step(4'd12, 3'd1, "reload_toB");
    chk("reload_a", alu_a, 4'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
